matrix_maxpool: RTL and testbench

Downstream consumer of the convolution accelerator's result matrix. Reads a signed 32-bit matrix from shared RAM and applies optional ReLU plus 2x2, stride-2 max pooling. Writes the pooled matrix back to RAM. Uses the same enable/done control and the same `mem_operation`/`mem_opdone` bus protocol as the other accelerators, so it sits on the same memory arbiter port type.

---
 rtl/matrix_maxpool.sv | 217 +++++++++++++++++++++
 tb/tb_matrix_maxpool.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_maxpool.sv
// matrix_maxpool
//   Reads a signed 32-bit matrix from shared RAM, applies 2x2 stride-2 max
//   pooling with optional ReLU clamp, and writes the pooled matrix back.
//   Job parameters come from a 4-word descriptor at DESC_BASE:
//   W_in, H_in, SRC base, DST base.
//
// Ports
//   clk            single clock
//   reset          synchronous, active-high
//   enable         starts a job from IDLE; must drop before the next job
//   mem_opdone     completion strobe for the outstanding request
//   data_i         read data, valid with mem_opdone during a read
//   data_o         write data
//   addr_o         word address
//   mem_operation  01 read, 11 write, 00 none
//   done           job complete, held until enable drops
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | waiting for enable
// START      | clear indices, max register and descriptor registers
// FETCH_DESC | read the 4 descriptor words
// CHECK      | skip to DONE when the pooled matrix is empty
// RD0..RD3   | read the four inputs of one 2x2 window, tracking the max
// POOL       | optional ReLU clamp of the window max
// WRITE      | store the pooled value
// NEXT       | advance column/row, or finish
// DONE       | done=1 until enable is released
module matrix_maxpool #(
  parameter logic [31:0] DESC_BASE = 32'h0000_0000,
  parameter bit          RELU      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_opdone,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [31:0] addr_o,
  output logic [1:0]  mem_operation,
  output logic        done
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_FETCH_DESC, S_CHECK,
    S_RD0, S_RD1, S_RD2, S_RD3,
    S_POOL, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [31:0] w_in, w_in_n, h_in, h_in_n, src, src_n, dst, dst_n;
  logic [31:0] i, i_n, j, j_n, max_r, max_n;
  logic [1:0]  k, k_n;
  logic [31:0] addr_n, data_n;
  logic [1:0]  op_n;

  logic [31:0] w_out, h_out, row0, row1, col;
  logic        busy;

  assign w_out = w_in >> 1;
  assign h_out = h_in >> 1;
  assign row0  = src + ((i << 1) * w_in);
  assign row1  = row0 + w_in;
  assign col   = j << 1;
  assign busy  = (mem_operation != OP_NONE);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      w_in          <= '0;
      h_in          <= '0;
      src           <= '0;
      dst           <= '0;
      i             <= '0;
      j             <= '0;
      max_r         <= '0;
      k             <= '0;
      addr_o        <= '0;
      data_o        <= '0;
      mem_operation <= OP_NONE;
    end else begin
      state         <= state_n;
      w_in          <= w_in_n;
      h_in          <= h_in_n;
      src           <= src_n;
      dst           <= dst_n;
      i             <= i_n;
      j             <= j_n;
      max_r         <= max_n;
      k             <= k_n;
      addr_o        <= addr_n;
      data_o        <= data_n;
      mem_operation <= op_n;
    end
  end

  // Every bus state follows the same pattern: with the bus idle, register a
  // request; with a request outstanding, wait for mem_opdone, then drop back
  // to OP_NONE. The first cycle of each state is therefore always idle,
  // which gives the mandatory gap between consecutive requests.
  always_comb begin
    state_n = state;
    w_in_n  = w_in;
    h_in_n  = h_in;
    src_n   = src;
    dst_n   = dst;
    i_n     = i;
    j_n     = j;
    max_n   = max_r;
    k_n     = k;
    addr_n  = addr_o;
    data_n  = data_o;
    op_n    = mem_operation;

    case (state)
      S_IDLE: if (enable) state_n = S_START;

      S_START: begin
        w_in_n  = '0;
        h_in_n  = '0;
        src_n   = '0;
        dst_n   = '0;
        i_n     = '0;
        j_n     = '0;
        max_n   = '0;
        k_n     = '0;
        state_n = S_FETCH_DESC;
      end

      S_FETCH_DESC: begin
        if (!busy) begin
          addr_n = DESC_BASE + {30'd0, k};
          op_n   = OP_RD;
        end else if (mem_opdone) begin
          op_n = OP_NONE;
          case (k)
            2'd0:    w_in_n = data_i;
            2'd1:    h_in_n = data_i;
            2'd2:    src_n  = data_i;
            default: dst_n  = data_i;
          endcase
          k_n = k + 2'd1;
          if (k == 2'd3) state_n = S_CHECK;
        end
      end

      S_CHECK: begin
        if (w_out == '0 || h_out == '0) begin
          state_n = S_DONE;
        end else begin
          i_n     = '0;
          j_n     = '0;
          state_n = S_RD0;
        end
      end

      S_RD0, S_RD1, S_RD2, S_RD3: begin
        if (!busy) begin
          case (state)
            S_RD0:   addr_n = row0 + col;
            S_RD1:   addr_n = row0 + col + 32'd1;
            S_RD2:   addr_n = row1 + col;
            default: addr_n = row1 + col + 32'd1;
          endcase
          op_n = OP_RD;
        end else if (mem_opdone) begin
          op_n = OP_NONE;
          if (state == S_RD0 || $signed(data_i) > $signed(max_r)) max_n = data_i;
          case (state)
            S_RD0:   state_n = S_RD1;
            S_RD1:   state_n = S_RD2;
            S_RD2:   state_n = S_RD3;
            default: state_n = S_POOL;
          endcase
        end
      end

      S_POOL: begin
        if (RELU && max_r[31]) max_n = '0;
        state_n = S_WRITE;
      end

      S_WRITE: begin
        if (!busy) begin
          addr_n = dst + (i * w_out) + j;
          data_n = max_r;
          op_n   = OP_WR;
        end else if (mem_opdone) begin
          op_n    = OP_NONE;
          state_n = S_NEXT;
        end
      end

      S_NEXT: begin
        if (j + 32'd1 == w_out) begin
          j_n = '0;
          i_n = i + 32'd1;
          if (i + 32'd1 == h_out) state_n = S_DONE;
          else                    state_n = S_RD0;
        end else begin
          j_n     = j + 32'd1;
          state_n = S_RD0;
        end
      end

      S_DONE: if (!enable) state_n = S_IDLE;

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_maxpool.sv
// tb_matrix_maxpool
//   Two DUT instances (RELU=1 and RELU=0) share one memory model; sel_relu
//   picks which one owns the bus. The memory responder answers each request
//   after a fixed or random latency, watches bus stability/idle gaps, and
//   checks every write against a queue produced by a behavioural pooling
//   model computed from a snapshot of memory before the job.
module tb_matrix_maxpool;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        sel_relu = 1'b1;
  logic        mem_opdone = 1'b0;
  logic [31:0] data_i = '0;

  logic [31:0] data_o1, addr_o1, data_o0, addr_o0;
  logic [1:0]  op1, op0;
  logic        done1, done0;

  logic [31:0] data_o, addr_o;
  logic [1:0]  mem_op;
  logic        done;

  always #5 clk = ~clk;

  matrix_maxpool #(.DESC_BASE(32'h0), .RELU(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable & sel_relu),
    .mem_opdone(mem_opdone & sel_relu), .data_i(data_i),
    .data_o(data_o1), .addr_o(addr_o1), .mem_operation(op1), .done(done1));

  matrix_maxpool #(.DESC_BASE(32'h0), .RELU(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable & ~sel_relu),
    .mem_opdone(mem_opdone & ~sel_relu), .data_i(data_i),
    .data_o(data_o0), .addr_o(addr_o0), .mem_operation(op0), .done(done0));

  assign data_o = sel_relu ? data_o1 : data_o0;
  assign addr_o = sel_relu ? addr_o1 : addr_o0;
  assign mem_op = sel_relu ? op1 : op0;
  assign done   = sel_relu ? done1 : done0;

  logic [31:0] mem [0:4095];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          lat_rand = 1'b0;
  int          rd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Memory responder and bus monitor.
  initial begin
    logic [1:0]  prev_op;
    logic        prev_done;
    logic [31:0] req_addr, req_data;
    logic [1:0]  req_op;
    int          cnt, cur_l;
    prev_op = 2'b00; prev_done = 1'b0; cnt = 0; cur_l = 1;
    req_addr = '0; req_data = '0; req_op = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_opdone = 1'b0;
        cnt = 0;
      end else if (mem_op == 2'b00) begin
        mem_opdone = 1'b0;
        cnt = 0;
      end else begin
        if (prev_op == 2'b00) begin
          if (mem_op == 2'b01) rd_cnt++;
          cur_l = lat_rand ? int'($urandom_range(1, 7)) : 1;
          cnt = 0;
          req_addr = addr_o; req_data = data_o; req_op = mem_op;
        end else begin
          check("bus_addr_stable", addr_o, req_addr);
          check("bus_data_stable", data_o, req_data);
          check("bus_op_stable", {30'd0, mem_op}, {30'd0, req_op});
          check("bus_idle_gap", {31'd0, prev_done}, 32'd0);
        end
        cnt++;
        if (cnt == cur_l) begin
          mem_opdone = 1'b1;
          if (mem_op == 2'b01) begin
            data_i = mem[addr_o[11:0]];
          end else begin
            mem[addr_o[11:0]] = data_o;
            if (exp_addr.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_write: addr %h data %h, none expected", addr_o, data_o);
            end else begin
              check("wr_addr", addr_o, exp_addr.pop_front());
              check("wr_data", data_o, exp_data.pop_front());
            end
          end
        end else begin
          mem_opdone = 1'b0;
        end
      end
      prev_op   = reset ? 2'b00 : mem_op;
      prev_done = mem_opdone;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Behavioural reference: max over each 2x2 window, then optional clamp.
  task automatic build_expected(input int w, input int h, input logic [31:0] src,
                                input logic [31:0] dst, input bit relu);
    int wo, ho;
    logic signed [31:0] m, v;
    wo = w / 2;
    ho = h / 2;
    exp_addr.delete();
    exp_data.delete();
    for (int r = 0; r < ho; r++)
      for (int c = 0; c < wo; c++) begin
        m = mem[(src + 2*r*w + 2*c) & 32'hFFF];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            v = mem[(src + (2*r+dr)*w + 2*c + dc) & 32'hFFF];
            if (v > m) m = v;
          end
        if (relu && m < 0) m = 0;
        exp_addr.push_back(dst + r*wo + c);
        exp_data.push_back(m);
      end
  endtask

  task automatic run_job(input int w, input int h, input logic [31:0] src,
                         input logic [31:0] dst, input bit relu, input bit lr,
                         input bit drop_mid, input int hold);
    int cyc;
    mem[0] = w; mem[1] = h; mem[2] = src; mem[3] = dst;
    sel_relu = relu;
    lat_rand = lr;
    build_expected(w, h, src, dst, relu);
    tick();
    enable = 1'b1;
    if (drop_mid) begin
      repeat (5) tick();
      enable = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 20000) begin
      tick();
      cyc++;
    end
    check("job_done", {31'd0, done}, 32'd1);
    check("writes_left", exp_addr.size(), 32'd0);
    if (!drop_mid) begin
      repeat (hold) tick();
      check("done_held", {31'd0, done}, 32'd1);
      check("no_restart", {30'd0, mem_op}, 32'd0);
    end
    enable = 1'b0;
    tick();
    check("done_drop", {31'd0, done}, 32'd0);
  endtask

  task automatic load_4x4();
    for (int n = 0; n < 16; n++) mem[12'h100 + n] = n + 1;
    for (int n = 0; n < 4; n++) mem[12'h200 + n] = 32'hDEAD_BEEF;
  endtask

  task automatic check_4x4();
    check("p4x4_0", mem[12'h200], 32'd6);
    check("p4x4_1", mem[12'h201], 32'd8);
    check("p4x4_2", mem[12'h202], 32'd14);
    check("p4x4_3", mem[12'h203], 32'd16);
  endtask

  initial begin
    int cyc, w, h;
    logic [31:0] src, dst;
    for (int n = 0; n < 4096; n++) mem[n] = '0;

    // reset state of both instances
    repeat (3) tick();
    check("rst_op1", {30'd0, op1}, 32'd0);
    check("rst_op0", {30'd0, op0}, 32'd0);
    check("rst_addr1", addr_o1, 32'd0);
    check("rst_data1", data_o1, 32'd0);
    check("rst_done1", {31'd0, done1}, 32'd0);
    check("rst_done0", {31'd0, done0}, 32'd0);
    reset = 1'b0;
    tick();

    // zero-size job: start latency and done timing with L=1
    mem[0] = 1; mem[1] = 8; mem[2] = 32'h100; mem[3] = 32'h200;
    sel_relu = 1'b1; lat_rand = 1'b0;
    exp_addr.delete(); exp_data.delete();
    enable = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e <= 3) check($sformatf("start_lat_e%0d", e), {30'd0, mem_op}, (e == 3) ? 32'd1 : 32'd0);
      check($sformatf("zero_done_e%0d", e), {31'd0, done}, (e >= 11) ? 32'd1 : 32'd0);
    end
    enable = 1'b0;
    tick();
    check("zero_done_drop", {31'd0, done}, 32'd0);

    // 4x4, fixed latency
    load_4x4();
    run_job(4, 4, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 2);
    check_4x4();

    // 3x5 negative data with a single positive entry
    for (int n = 0; n < 15; n++) mem[12'h100 + n] = -32'sd5;
    mem[12'h100 + 3*3 + 1] = 32'd7;
    mem[12'h200] = 32'hDEAD_BEEF; mem[12'h201] = 32'hDEAD_BEEF;
    run_job(3, 5, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 1);
    check("neg_relu_0", mem[12'h200], 32'd0);
    check("neg_relu_1", mem[12'h201], 32'd7);
    mem[12'h200] = 32'hDEAD_BEEF; mem[12'h201] = 32'hDEAD_BEEF;
    run_job(3, 5, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0, 1);
    check("neg_norelu_0", mem[12'h200], 32'hFFFF_FFFB);
    check("neg_norelu_1", mem[12'h201], 32'd7);

    // 4x4 with random latency per transaction
    load_4x4();
    run_job(4, 4, 32'h100, 32'h200, 1'b1, 1'b1, 1'b0, 0);
    check_4x4();

    // reset during RD2 of the third output element, then rerun
    load_4x4();
    mem[0] = 4; mem[1] = 4; mem[2] = 32'h100; mem[3] = 32'h200;
    sel_relu = 1'b1; lat_rand = 1'b0;
    build_expected(4, 4, 32'h100, 32'h200, 1'b1);
    rd_cnt = 0;
    enable = 1'b1;
    cyc = 0;
    while (!(rd_cnt == 15 && mem_op == 2'b01) && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("reach_rd2_elem3", rd_cnt, 32'd15);
    reset = 1'b1;
    enable = 1'b0;
    tick();
    check("midrst_op", {30'd0, mem_op}, 32'd0);
    check("midrst_addr", addr_o, 32'd0);
    check("midrst_data", data_o, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    tick();
    load_4x4();
    run_job(4, 4, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 0);
    check_4x4();

    // randomized jobs
    for (int t = 0; t < 20; t++) begin
      w = $urandom_range(0, 7);
      h = $urandom_range(0, 7);
      src = 32'h100 + $urandom_range(0, 32'h500);
      dst = ($urandom_range(0, 4) == 0) ? src : 32'h800 + $urandom_range(0, 32'h500);
      for (int n = 0; n < w*h; n++) mem[(src + n) & 32'hFFF] = $urandom;
      run_job(w, h, src, dst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
